// File: rtl/seq_divider_8bit.sv
// Iterative restoring unsigned divider: one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and reports all-ones quotient with R = A.

module seq_divider_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]  div_q, div_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              zero_q, zero_d; // zero-divisor result pending for next edge
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    rem_sub;
  logic              ge;
  logic [WIDTH:0]    rem_step;
  logic [WIDTH-1:0]  dvd_step;

  always_comb begin
    rem_sh   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, div_q};
    ge       = (rem_sh >= {1'b0, div_q});
    rem_step = ge ? rem_sub : rem_sh;
    dvd_step = {dvd_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      StIdle, StDone: begin
        if (zero_q) begin
          q_d     = {WIDTH{1'b1}};
          r_d     = dvd_q;
          dbz_d   = 1'b1;
          zero_d  = 1'b0;
          state_d = StDone;
        end else if (start) begin
          dvd_d = A;
          div_d = B;
          rem_d = '0;
          cnt_d = '0;
          if (B == '0) begin
            zero_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRun;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        rem_d = rem_step;
        dvd_d = dvd_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastStep) begin
          q_d     = dvd_step;
          r_d     = rem_step[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Directed bench for seq_divider_8bit: latency, back-to-back, zero divisor,
// ignored restart, mid-run reset, and a sampled operand sweep.

module tb_seq_divider_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider_8bit #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for done; checks latency, busy level before done, and that Q/R hold.
  task automatic wait_done(input int exp_lat, input logic exp_busy, input string tag);
    int         n        = 0;
    logic       bad_busy = 1'b0;
    logic       bad_hold = 1'b0;
    logic [7:0] q0       = Q;
    logic [7:0] r0       = R;
    while (!done && n < 40) begin
      if (busy !== exp_busy) bad_busy = 1'b1;
      if (Q !== q0 || R !== r0) bad_hold = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_busy"}, {31'd0, bad_busy}, 32'd0);
    chk({tag, "_hold"}, {31'd0, bad_hold}, 32'd0);
  endtask

  initial begin
    int         n;
    logic       extra_done;
    logic [7:0] a;
    logic [7:0] b;

    rst   = 1'b1;
    start = 1'b0;
    A     = 8'd0;
    B     = 8'd0;
    tick();
    tick();
    chk("rst_q", Q, 0);
    chk("rst_r", R, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    tick();

    // T1
    do_start(8'd12, 8'd2);
    wait_done(8, 1'b1, "t1");
    chk("t1_q", Q, 6);
    chk("t1_r", R, 0);
    chk("t1_dbz", div_by_zero, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // T2: second start issued in the DONE cycle
    do_start(8'd93, 8'd3);
    wait_done(8, 1'b1, "t2a");
    chk("t2a_q", Q, 31);
    chk("t2a_r", R, 0);
    do_start(8'd100, 8'd7);
    chk("t2_b2b_busy", busy, 1);
    chk("t2_b2b_done", done, 0);
    wait_done(8, 1'b1, "t2b");
    chk("t2b_q", Q, 14);
    chk("t2b_r", R, 2);
    tick();

    // T3
    do_start(8'd255, 8'd0);
    wait_done(1, 1'b0, "t3");
    chk("t3_q", Q, 255);
    chk("t3_r", R, 255);
    chk("t3_dbz", div_by_zero, 1);
    tick();
    chk("t3_done_pulse", done, 0);
    chk("t3_dbz_hold", div_by_zero, 1);
    chk("t3_q_hold", Q, 255);
    do_start(8'd30, 8'd6);
    wait_done(8, 1'b1, "t3b");
    chk("t3b_q", Q, 5);
    chk("t3b_r", R, 0);
    chk("t3b_dbz", div_by_zero, 0);
    tick();

    // T4: restart request and operand change during RUN are ignored
    do_start(8'd200, 8'd13);
    n = 0;
    while (!done && n < 40) begin
      if (n == 3) begin
        start = 1'b1;
        A     = 8'd77;
        B     = 8'd5;
      end
      tick();
      start = 1'b0;
      n++;
    end
    chk("t4_lat", n, 8);
    chk("t4_q", Q, 15);
    chk("t4_r", R, 5);
    extra_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) extra_done = 1'b1;
    end
    chk("t4_single_done", extra_done, 0);
    chk("t4_idle_busy", busy, 0);

    // T5: reset aborts a division mid-run
    do_start(8'd255, 8'd1);
    tick();
    tick();
    tick();
    chk("t5_running", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_q", Q, 0);
    chk("t5_r", R, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    extra_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) extra_done = 1'b1;
    end
    chk("t5_no_done", extra_done, 0);
    do_start(8'd255, 8'd255);
    wait_done(8, 1'b1, "t5b");
    chk("t5b_q", Q, 1);
    chk("t5b_r", R, 0);

    // T6: sampled sweep, back-to-back, including corner operands
    for (int i = 0; i < 1500; i++) begin
      case (i)
        0:       begin a = 8'd0;   b = 8'd255; end
        1:       begin a = 8'd255; b = 8'd1;   end
        2:       begin a = 8'd1;   b = 8'd255; end
        3:       begin a = 8'd128; b = 8'd128; end
        4:       begin a = 8'd254; b = 8'd255; end
        default: begin
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(1, 255));
        end
      endcase
      do_start(a, b);
      wait_done(8, 1'b1, "sweep");
      chk("sweep_q", Q, a / b);
      chk("sweep_r", R, a % b);
      chk("sweep_dbz", div_by_zero, 0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
